// File: rtl/mux_rr_stream_pkg.sv
// Shared constants for the streaming mux: mode encodings and a ceil-log2 helper
// for callers that derive the channel-index width from the channel count.
package mux_rr_stream_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  function automatic int clog2_f(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mux_rr_stream_if.sv
// Bundle of the N producer channels, the select controls and the single
// consumer port; the design uses the slave view, the environment the master view.
interface mux_rr_stream_if #(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  parameter int SELW  = 2
) ();

  logic                 mode;
  logic [SELW-1:0]      sel;
  logic [N*WIDTH-1:0]   in_data;
  logic [N-1:0]         in_valid;
  logic [N-1:0]         in_ready;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_chan;
  logic                 out_valid;
  logic                 out_ready;

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );

endinterface

// File: rtl/mux_rr_stream_rr_pick.sv
// Combinational round-robin finder: first requesting channel at or after ptr,
// wrapping past N-1 back to 0. ptr is expected to stay below N.
module rr_pick #(
  parameter int N    = 4,
  parameter int SELW = 2
) (
  input  logic [N-1:0]    req_i,
  input  logic [SELW-1:0] ptr_i,
  output logic [SELW-1:0] gnt_idx_o,
  output logic            gnt_any_o
);

  logic [2*N-1:0] req_dbl_s;
  logic [N-1:0]   rot_s;
  int             off_s;
  int             sum_s;

  // Doubling the vector turns the wrapped scan into a plain shift.
  assign req_dbl_s = {req_i, req_i};
  assign rot_s     = N'(req_dbl_s >> ptr_i);
  assign gnt_any_o = |req_i;

  // Lowest set bit of the rotated vector is the offset from ptr.
  always_comb begin
    off_s = 0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot_s[j]) begin
        off_s = j;
      end else begin
        off_s = off_s;
      end
    end
    sum_s = int'(ptr_i) + off_s;
    if (sum_s >= N) begin
      sum_s = sum_s - N;
    end else begin
      sum_s = sum_s;
    end
    gnt_idx_o = SELW'(sum_s);
  end

endmodule

// File: rtl/mux_rr_stream.sv
// N-way valid/ready stream mux with one registered output stage; selects the
// source directly from sel or by round-robin over the valid channels.
module mux_rr_stream
  import mux_rr_stream_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  parameter int SELW  = 2
) (
  input  logic              clk,
  input  logic              reset,
  mux_rr_stream_if.slave    bus
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]  out_chan_q,  out_chan_d;
  logic [SELW-1:0]  ptr_q,       ptr_d;

  logic             load_s;
  logic [SELW-1:0]  rr_idx_s;
  logic             rr_any_s;
  logic [SELW-1:0]  chosen_s;
  logic             chosen_ok_s;
  logic [N-1:0]     in_ready_s;
  logic [WIDTH-1:0] data_sel_s;
  logic             xfer_s;

  rr_pick #(.N(N), .SELW(SELW)) u_rr_pick (
    .req_i     (bus.in_valid),
    .ptr_i     (ptr_q),
    .gnt_idx_o (rr_idx_s),
    .gnt_any_o (rr_any_s)
  );

  assign load_s = !out_valid_q || bus.out_ready;

  // Source selection; an out-of-range sel selects nothing.
  always_comb begin
    chosen_s    = '0;
    chosen_ok_s = 1'b0;
    case (bus.mode)
      MODE_SEL: begin
        chosen_s    = bus.sel;
        chosen_ok_s = (int'(bus.sel) < N);
      end
      MODE_RR: begin
        chosen_s    = rr_idx_s;
        chosen_ok_s = rr_any_s;
      end
      default: begin
        chosen_s    = '0;
        chosen_ok_s = 1'b0;
      end
    endcase
  end

  // Ready decode and AND-OR data mux; ready is forced low during reset.
  always_comb begin
    in_ready_s = '0;
    data_sel_s = '0;
    for (int i = 0; i < N; i++) begin
      in_ready_s[i] = chosen_ok_s && load_s && !reset && (chosen_s == SELW'(i));
      data_sel_s    = data_sel_s
                    | ({WIDTH{chosen_s == SELW'(i)}} & bus.in_data[i*WIDTH +: WIDTH]);
    end
    xfer_s = |(in_ready_s & bus.in_valid);
  end

  // Next state of the output stage and the round-robin pointer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    ptr_d       = ptr_q;
    if (xfer_s) begin
      out_valid_d = 1'b1;
      out_data_d  = data_sel_s;
      out_chan_d  = chosen_s;
      if (bus.mode == MODE_RR) begin
        ptr_d = (chosen_s == SELW'(N - 1)) ? '0 : chosen_s + 1'b1;
      end else begin
        ptr_d = ptr_q;
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Output register and pointer state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.out_valid = out_valid_q;

endmodule
